// File: rtl/regfile_operand_reader_pkg.sv
// Shared constants for the operand-reader register file.
package regfile_operand_reader_pkg;

    localparam int unsigned ZERO_REG            = 0;
    localparam int unsigned DEFAULT_WORD_LENGTH = 32;
    localparam int unsigned DEFAULT_ADDR_LENGTH = 5;

endpackage

// File: rtl/regfile_operand_reader_operand_latch.sv
// Enable-loaded operand register with asynchronous active-low clear.
module operand_latch
    import regfile_operand_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WORD_LENGTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/regfile_operand_reader.sv
// Register file with one write port and two latched read operands.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the operands.
module regfile_operand_reader
    import regfile_operand_reader_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter int unsigned ADDR_LENGTH = DEFAULT_ADDR_LENGTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_LENGTH-1:0] wr_addr,
    input  logic [WORD_LENGTH-1:0] wr_data,
    input  logic                   rd_req,
    input  logic [ADDR_LENGTH-1:0] rs_addr,
    input  logic [ADDR_LENGTH-1:0] rt_addr,
    output logic [WORD_LENGTH-1:0] A_out,
    output logic [WORD_LENGTH-1:0] B_out,
    output logic                   rd_valid
);

    localparam int unsigned            DEPTH     = 2 ** ADDR_LENGTH;
    localparam logic [ADDR_LENGTH-1:0] ZERO_ADDR = ADDR_LENGTH'(ZERO_REG);

    logic [WORD_LENGTH-1:0] mem [DEPTH];
    logic                   wr_hit;
    logic [WORD_LENGTH-1:0] rs_data;
    logic [WORD_LENGTH-1:0] rt_data;

    assign wr_hit = wr_en && (wr_addr != ZERO_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[ADDR_LENGTH'(i)] <= '0;
        end else if (wr_hit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Index 0 is forced to zero on read regardless of array contents.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != ZERO_ADDR)
            rs_data = mem[rs_addr];
        if (rt_addr != ZERO_ADDR)
            rt_data = mem[rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (wr_addr == rs_addr))
            rs_data = wr_data;
        if (wr_hit && (wr_addr == rt_addr))
            rt_data = wr_data;
`endif
    end

    operand_latch #(.WIDTH(WORD_LENGTH)) u_latch_a (
        .clk   (clk),
        .reset (reset),
        .en    (rd_req),
        .d     (rs_data),
        .q     (A_out)
    );

    operand_latch #(.WIDTH(WORD_LENGTH)) u_latch_b (
        .clk   (clk),
        .reset (reset),
        .en    (rd_req),
        .d     (rt_data),
        .q     (B_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_valid <= 1'b0;
        else
            rd_valid <= rd_req;
    end

endmodule

// File: tb/tb_regfile_operand_reader.sv
// Scoreboard bench for regfile_operand_reader: directed cases plus random traffic.
module tb_regfile_operand_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] A_out;
    logic [31:0] B_out;
    logic        rd_valid;

    regfile_operand_reader #(.WORD_LENGTH(32), .ADDR_LENGTH(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .A_out    (A_out),
        .B_out    (B_out),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural view: register 0 is zero; a same-cycle write is seen only with forwarding.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
        sb.delete();
        last_a = '0;
        last_b = '0;
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rq, input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req = rq; rs_addr = ra; rt_addr = rb;
        if (rq) begin
            e.cyc = cyc + 1;
            e.a   = ref_read(ra, we, wa, wd);
            e.b   = ref_read(rb, we, wa, wd);
            sb.push_back(e);
        end
        if (we && wa != 5'd0) model[wa] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    endtask

    // Monitor: one sample per cycle, 1 time unit after the active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rd_valid", 32'(rd_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rd_valid_cycle", cyc, e.cyc);
                chk("A_out", A_out, e.a);
                chk("B_out", B_out, e.b);
                last_a = e.a;
                last_b = e.b;
            end
        end else begin
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("missing_rd_valid", 32'(rd_valid), 32'h1);
            end
            chk("A_hold", A_out, last_a);
            chk("B_hold", B_out, last_b);
        end
    end

    initial begin
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rs_addr = '0; rt_addr = '0;
        clear_model();
        #1;
        chk("reset_A", A_out, 32'h0);
        chk("reset_B", B_out, 32'h0);
        chk("reset_valid", 32'(rd_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // First edge after release reads normally; cleared registers read zero.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
        idle(2);

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        idle(1);

        step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd5);
        idle(1);

        step(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
        idle(1);

        step(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd3);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd1);
        idle(4);

        // Write and read of different indices in the same cycle are independent.
        step(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd1, 5'd2);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3);
        idle(1);

        // Captured read, then a second read killed by reset before its edge.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd9);
        @(negedge clk);
        rd_req = 1'b1; rs_addr = 5'd5; rt_addr = 5'd9;
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        chk("midreset_A", A_out, 32'h0);
        chk("midreset_B", B_out, 32'h0);
        chk("midreset_valid", 32'(rd_valid), 32'h0);
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd9);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            logic        we, rq;
            logic [4:0]  wa, ra, rb;
            we = 1'($urandom_range(0, 1));
            rq = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) != 0) begin
                wa = wa & 5'h7; ra = ra & 5'h7; rb = rb & 5'h7;
            end
            step(we, wa, $urandom, rq, ra, rb);
        end
        idle(3);

        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/regfile_operand_reader.md
REGFILE_OPERAND_READER -- requirements
Module: regfile_operand_reader

Interface
REQ-001 Parameter WORD_LENGTH, default 32, data width of each register and operand.
REQ-002 Parameter ADDR_LENGTH, default 5, register-index width; depth = 2**ADDR_LENGTH.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write strobe for the write port.
REQ-006 wr_addr  input  ADDR_LENGTH  write index, held stable by the upstream write-select register.
REQ-007 wr_data  input  WORD_LENGTH  write data.
REQ-008 rd_req  input  1  read request; samples rs_addr/rt_addr this cycle.
REQ-009 rs_addr  input  ADDR_LENGTH  first source index.
REQ-010 rt_addr  input  ADDR_LENGTH  second source index.
REQ-011 A_out  output  WORD_LENGTH  latched operand A.
REQ-012 B_out  output  WORD_LENGTH  latched operand B.
REQ-013 rd_valid  output  1  one-cycle pulse: A_out/B_out updated from the previous rd_req.

Function
REQ-014 The storage array SHALL hold 2**ADDR_LENGTH words and SHALL write wr_data to wr_addr on a rising edge when wr_en=1 and wr_addr!=0.
REQ-015 Index 0 SHALL always read as 0; writes to index 0 SHALL be discarded.
REQ-016 On a rising edge with rd_req=1, A_out/B_out SHALL load the contents of rs_addr/rt_addr; latency is exactly one cycle from rd_req to data visible.
REQ-017 rd_valid SHALL be 1 in the cycle after each cycle with rd_req=1 and 0 otherwise; back-to-back rd_req SHALL give back-to-back rd_valid with no bubble.
REQ-018 When rd_req=0, A_out/B_out SHALL hold their last values indefinitely.
REQ-019 Same-cycle write and read of one nonzero index SHALL follow REQ-031/REQ-032.
REQ-020 rs_addr==rt_addr SHALL return the same value on A_out and B_out.
REQ-021 Simultaneous wr_en and rd_req to different indices SHALL be independent; the write is visible to any rd_req in a later cycle.

Reset
REQ-022 reset=0 SHALL asynchronously clear every storage word, A_out, B_out and rd_valid to 0.
REQ-023 A read in flight when reset asserts SHALL be dropped; no rd_valid pulse after reset release for it.
REQ-024 The first rising edge after reset release SHALL accept wr_en and rd_req normally.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-026 Defined: behaviour per REQ-031.
REQ-027 Undefined: behaviour per REQ-032; no forwarding logic synthesized.

Structure
REQ-028 A shared package SHALL hold the ZERO_REG index constant (0) and default WORD_LENGTH/ADDR_LENGTH constants.
REQ-029 The A/B operand latches SHALL be one sub-module, operand_latch (enable-loaded register with async active-low clear), instantiated twice.
REQ-030 The storage array SHALL be in the top module; no other sub-modules.
REQ-031 With REGFILE_BYPASS_EN: if wr_en=1, wr_addr!=0 and rd_req=1 with rs_addr or rt_addr == wr_addr in the same cycle, the matching operand SHALL load wr_data.
REQ-032 Without REGFILE_BYPASS_EN: the matching operand SHALL load the pre-write stored value.

Verification
REQ-033 Reset, then rd_req rs=3 rt=0 -> next cycle A_out=0, B_out=0, rd_valid=1 one cycle.
REQ-034 Write 0xDEADBEEF to 5, next cycle rd_req rs=5 rt=5 -> A_out=B_out=0xDEADBEEF, rd_valid=1.
REQ-035 Write 0x12345678 to 0, then read rs=0 -> A_out=0.
REQ-036 Reg 7=0x1, same cycle write 0x2 to 7 and rd_req rs=7 -> A_out=0x2 with REGFILE_BYPASS_EN, 0x1 without.
REQ-037 rd_req three consecutive cycles rs=1,2,3 (preloaded 0x11,0x22,0x33) -> rd_valid high three cycles, A_out 0x11,0x22,0x33.
REQ-038 rd_req then reset=0 mid-cycle -> A_out=0, rd_valid=0, no pulse after release.
